// File: rtl/serial_subtractor4_pkg.sv
// Shared arithmetic-library definitions: serial subtractor state encoding,
// default width and a word-level reference subtraction.
package arith_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {Bout, D} in bits [16] and [15:0]; D is masked to w bits.
    function automatic logic [16:0] ref_sub(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic        bin,
                                            input int unsigned w);
        logic [15:0] mask;
        logic [15:0] d;
        logic [16:0] lhs;
        logic [16:0] rhs;
        mask = (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 32'd1);
        d    = (a - b - 16'(bin)) & mask;
        lhs  = {1'b0, a & mask};
        rhs  = {1'b0, b & mask} + 17'(bin);
        return {(lhs < rhs), d};
    endfunction

endpackage

// File: rtl/serial_subtractor4_fs.sv
// Single-bit full subtractor cell, the borrow counterpart of the ripple-adder
// full-adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor D = A - B - Bin, LSB first through one full-subtractor
// cell, with a start/busy/done handshake.
module serial_subtractor4
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Bin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Bout,
    output logic [WIDTH-1:0] D
);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   areg;
    logic [WIDTH-1:0]   breg;
    logic [WIDTH-2:0]   res;
    logic [WIDTH-1:0]   res_nx;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               fs_d;
    logic               fs_bout;

    full_subtractor u_fs (
        .a    (areg[0]),
        .b    (breg[0]),
        .bin  (borrow),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // res keeps only the upper WIDTH-1 bits; the final bit joins on the last edge
    assign res_nx = {fs_d, res};
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg   <= '0;
            breg   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        areg   <= A;
                        breg   <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    res    <= res_nx[WIDTH-1:1];
                    borrow <= fs_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        D    <= res_nx;
                        Bout <= fs_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor4.md
Name: serial_subtractor4

Overview:
- Bit-serial WIDTH-bit subtractor: computes D = A - B - Bin, one bit per clock, LSB first, through a single full-subtractor cell.
- The subtract-direction counterpart of the parallel 4-bit ripple adder in the arithmetic library.
- Used where area matters more than latency; a start/busy/done handshake lets a controller or bench sequence operations.

Parameters:
- WIDTH, 4, operand and result width in bits (legal: 2..16).
- CNT_W, $clog2(WIDTH+1), bit counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Bin  input  1  borrow-in, captured with start.
- A  input  WIDTH  minuend, captured with start.
- B  input  WIDTH  subtrahend, captured with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: D/Bout are valid.
- Bout  output  1  borrow-out of the MSB.
- D  output  WIDTH  difference, modulo 2^WIDTH.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, Bout=0, D=0; internal shift regs, borrow flop and counter all cleared. rst has priority over every other input.
- States: IDLE, SHIFT, DONE. Encoding is in the package.
- IDLE: at edge E0 with start=1, capture A, B into shift regs, Bin into the borrow flop, counter=0, go to SHIFT. With start=0, stay in IDLE. D/Bout hold their last result.
- SHIFT: busy=1. At each edge, the cell takes a=Areg[0], b=Breg[0], bin=borrow.
  - d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - d shifts into the result register from the MSB side; Areg/Breg shift right; borrow<=bout; counter++.
  - After WIDTH edges (E1..E_WIDTH), go to DONE. On edge E_WIDTH, D takes the completed result register and Bout takes the final borrow.
- DONE: done=1 and busy=0 for exactly one cycle. At the next edge, go to IDLE.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after start is sampled. For WIDTH=4: start sampled at E0, done high between E4 and E5.
- start while in SHIFT or DONE: ignored; no queueing and no effect on the operation in flight.
- A/B/Bin changing after E0: no effect; operands are captured.
- D and Bout change only at E_WIDTH or on reset. They are stable at all other times, including while the next operation is in SHIFT.
- Reset asserted mid-SHIFT: abort. Next cycle state=IDLE and all outputs are at reset values, with no done pulse.
- Wrap-around: A<B+Bin gives the two's-complement result mod 2^WIDTH with Bout=1.
- Bout=1 exactly when A < B+Bin, treating operands as unsigned.
- start held high continuously: a new operation begins in the cycle after DONE. Throughput is one result per WIDTH+2 cycles.

Decomposition:
- Package arith_pkg holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default WIDTH localparam;
  - a function ref_sub(A,B,Bin) returning {Bout,D}, for use by the bench scoreboard.
- One sub-module, full_subtractor (a, b, bin -> d, bout), purely combinational and instantiated once. It mirrors the full-adder cell used by the ripple adder.

Test Plan:
- Reset, then Bin=0, A=0, B=0, start pulse. Required: done at E0+5; D=4'd0, Bout=0; busy high for exactly 4 cycles.
- Bin=0, A=5, B=3. Required: D=4'd2, Bout=0.
- Bin=0, A=3, B=5. Required: D=4'b1110, Bout=1 (wrap-around). Bin=1, A=0, B=0. Required: D=4'b1111, Bout=1.
- Bin=1, A=4'b1111, B=4'b1111. Required: D=4'b1111, Bout=1. Bin=1, A=2, B=3 issued back-to-back with start held high. Required: second done exactly 6 cycles after the first; D=4'b1110, Bout=1.
- Start A=9, B=1. Pulse start again with A=0, B=7 two cycles later (during SHIFT). Required: second request ignored; one done only; D=4'd8, Bout=0.
- Start A=9, B=1, then assert rst at E2. Required: next cycle busy=0, done=0, D=0, Bout=0, state IDLE, and no done pulse. A subsequent A=6, B=6 gives D=0, Bout=0.
